// File: rtl/rgb_mode_sequencer.sv
// rgb_mode_sequencer
//   Drives the board RGB LED from the single user push-button. The raw button
//   is synchronised and debounced. Each clean press moves the mode FSM one step:
//   OFF -> RED -> GREEN -> BLUE -> CYCLE -> OFF. In CYCLE mode the colour rotates
//   automatically, staying on each colour for STEP_CYCLES clocks.
//
//   Ports
//     clk    in   system clock
//     reset  in   asynchronous, active-low reset
//     button in   raw push-button, asynchronous to clk, active-high
//     red    out  red LED drive (registered)
//     green  out  green LED drive (registered)
//     blue   out  blue LED drive (registered)
//     mode   out  current mode: 0 OFF, 1 RED, 2 GREEN, 3 BLUE, 4 CYCLE
//     press  out  one-cycle pulse on the edge where a debounced press is accepted
//
//   Optional feature: define RGB_PWM_EN to dim the LEDs. A free-running
//   PWM_BITS counter gates each lit output. The gate is open for PWM_DUTY out of
//   every 2**PWM_BITS cycles.
module rgb_mode_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] STEP_CYCLES     = 32'd50000000,
  parameter int          PWM_BITS        = 8,
  parameter int          PWM_DUTY        = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [2:0] mode,
  output logic       press
);

  // Widen the parameters before adding 1, so that the maximum legal values do not wrap.
  localparam int DW = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam int SW = $clog2(64'(STEP_CYCLES) + 64'd1);
  localparam logic [DW-1:0] DEB_TERM  = DW'(DEBOUNCE_CYCLES - 16'd1);
  localparam logic [SW-1:0] STEP_TERM = SW'(STEP_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    M_OFF   = 3'd0,
    M_RED   = 3'd1,
    M_GREEN = 3'd2,
    M_BLUE  = 3'd3,
    M_CYCLE = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    C_RED   = 2'd0,
    C_GREEN = 2'd1,
    C_BLUE  = 2'd2
  } col_e;

  // ---------------------------------------------------------------- sync
  logic s1, s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  // ------------------------------------------------------------ debounce
  // db follows s2 only after s2 has disagreed with it for DEBOUNCE_CYCLES
  // consecutive edges. Any agreeing cycle clears the run.
  logic          db;
  logic [DW-1:0] deb_cnt;
  logic          mism, deb_done, accept;

  assign mism     = (s2 != db);
  assign deb_done = mism && (deb_cnt == DEB_TERM);
  assign accept   = deb_done && s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db      <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      press <= accept;
      if (!mism) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        db      <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ mode FSM
  mode_e         mode_q, mode_d;
  col_e          col_q, col_d;
  logic [SW-1:0] step_q, step_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= M_OFF;
      col_q  <= C_RED;
      step_q <= '0;
    end else begin
      mode_q <= mode_d;
      col_q  <= col_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    col_d  = col_q;
    step_d = step_q;
    if (accept) begin
      // A press takes priority over a coincident step terminal count, so the
      // colour does not rotate on the edge where CYCLE is left.
      case (mode_q)
        M_OFF:   mode_d = M_RED;
        M_RED:   mode_d = M_GREEN;
        M_GREEN: mode_d = M_BLUE;
        M_BLUE:  mode_d = M_CYCLE;
        default: mode_d = M_OFF;
      endcase
      if (mode_d == M_CYCLE) begin
        step_d = '0;
        col_d  = C_RED;
      end
    end else if (mode_q == M_CYCLE) begin
      if (step_q == STEP_TERM) begin
        step_d = '0;
        case (col_q)
          C_RED:   col_d = C_GREEN;
          C_GREEN: col_d = C_BLUE;
          default: col_d = C_RED;
        endcase
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  assign mode = mode_q;

  // --------------------------------------------------------- LED decode
  logic [2:0] rgb_d;   // {red, green, blue}

  always_comb begin
    rgb_d = 3'b000;
    case (mode_q)
      M_RED:   rgb_d = 3'b100;
      M_GREEN: rgb_d = 3'b010;
      M_BLUE:  rgb_d = 3'b001;
      M_CYCLE: begin
        case (col_q)
          C_RED:   rgb_d = 3'b100;
          C_GREEN: rgb_d = 3'b010;
          default: rgb_d = 3'b001;
        endcase
      end
      default: rgb_d = 3'b000;
    endcase
  end

  logic pwm_on;

`ifdef RGB_PWM_EN
  // The duty is compared with one extra bit, so that PWM_DUTY = 2**PWM_BITS keeps the gate open.
  localparam logic [PWM_BITS:0] DUTY = (PWM_BITS + 1)'(PWM_DUTY);
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_on = ({1'b0, pwm_cnt} < DUTY);
`else
  // The PWM parameters have no effect in this build.
  logic unused_pwm_cfg;
  assign unused_pwm_cfg = ^{PWM_BITS[0], PWM_DUTY[0]};
  assign pwm_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      {red, green, blue} <= rgb_d & {3{pwm_on}};
    end
  end

endmodule

// File: tb/tb_rgb_mode_sequencer.sv
module tb_rgb_mode_sequencer;
  localparam int D  = 4;
  localparam int S  = 8;
  localparam int PB = 2;
  localparam int PD = 1;

  logic       clk, reset, button;
  logic       red, green, blue, press;
  logic [2:0] mode;

  rgb_mode_sequencer #(
    .DEBOUNCE_CYCLES(16'(D)),
    .STEP_CYCLES    (32'(S)),
    .PWM_BITS       (PB),
    .PWM_DUTY       (PD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .red   (red),
    .green (green),
    .blue  (blue),
    .mode  (mode),
    .press (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. Time is counted in clock edges. The sync chain is a two-deep delay.
  // A level change is accepted after the synchronised input has disagreed for D straight edges.
  // The CYCLE colour is (edges since entering CYCLE / S) mod 3.
  int         q1, q2, db, run, mm, mn, mpwm;
  logic [2:0] led_e;
  logic       press_e;

  function automatic logic [2:0] decode(input int m, input int n);
    case (m)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      4: begin
        case ((n / S) % 3)
          0:       return 3'b100;
          1:       return 3'b010;
          default: return 3'b001;
        endcase
      end
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    q1 = 0; q2 = 0; db = 0; run = 0; mm = 0; mn = 0; mpwm = 0;
    led_e = 3'b000; press_e = 1'b0;
  endtask

  task automatic model_edge(input bit b);
    logic [2:0] nl;
    bit acc;
    nl = decode(mm, mn);
`ifdef RGB_PWM_EN
    if (!(mpwm < PD)) nl = 3'b000;
    mpwm = (mpwm + 1) % (1 << PB);
`endif
    acc = 1'b0;
    if (q2 != db) begin
      run++;
      if (run == D) begin
        db  = q2;
        run = 0;
        acc = (q2 == 1);
      end
    end else begin
      run = 0;
    end
    if (acc) begin
      mm = (mm + 1) % 5;
      mn = 0;
    end else if (mm == 4) begin
      mn++;
    end
    q2 = q1;
    q1 = int'(b);
    led_e   = nl;
    press_e = acc;
  endtask

  // One clock edge: drive the button, let the edge happen, then compare.
  task automatic step(input bit b);
    button = b;
    @(posedge clk);
    model_edge(b);
    #1;
    chk("mode", 32'(mode), 32'(mm));
    chk("press", 32'(press), 32'(press_e));
    chk("rgb", 32'({red, green, blue}), 32'(led_e));
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic press_release();
    hold(1'b1, 8);
    hold(1'b0, 8);
  endtask

  // Keeps reset asserted for n edges, with random activity on the button, and checks that the outputs stay idle.
  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      button = 1'($urandom % 2);
      @(posedge clk);
      #1;
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_press", 32'(press), 32'd0);
      chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    end
    model_reset();
  endtask

  task automatic async_reset(input int n);
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_rgb", 32'({red, green, blue}), 32'd0);
    chk("arst_press", 32'(press), 32'd0);
    rst_cycles(n);
    reset  = 1'b1;
    button = 1'b0;
  endtask

  initial begin
    int guard;
    reset  = 1'b0;
    button = 1'b0;
    model_reset();

    // Reset with button activity.
    rst_cycles(3);
    reset = 1'b1;

    // Clean press held for 10 clocks.
    hold(1'b1, 10);
    chk("hold_mode", 32'(mode), 32'd1);
    chk("hold_rgb", 32'({red, green, blue}), 32'(3'b100 & {3{`ifdef RGB_PWM_EN 1'b0 `else 1'b1 `endif}}) | 32'(led_e));
    hold(1'b0, 8);

    // Glitches: pulses of 1 and 3 clocks, then a 6-clock window with a 2-clock gap.
    hold(1'b1, 1); hold(1'b0, 6);
    hold(1'b1, 3); hold(1'b0, 6);
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 6);
    chk("glitch_mode", 32'(mode), 32'd1);

    // Full sequence back to OFF, then on into CYCLE.
    for (int i = 0; i < 4; i++) press_release();
    chk("seq_off", 32'(mode), 32'd0);
    for (int i = 0; i < 4; i++) press_release();
    chk("seq_cycle", 32'(mode), 32'd4);

    // Rotation for 24 clocks, then a press that lands on a terminal count.
    hold(1'b0, 24);
    guard = 0;
    while ((mn % S) != 2 && guard < 3 * S) begin
      step(1'b0);
      guard++;
    end
    chk("term_align", 32'(mn % S), 32'd2);
    hold(1'b1, 8);
    chk("term_mode", 32'(mode), 32'd0);
    chk("term_rgb", 32'({red, green, blue}), 32'd0);
    hold(1'b0, 8);

    // Reset in the middle of CYCLE and in the middle of a debounce.
    for (int i = 0; i < 4; i++) press_release();
    hold(1'b0, 11);
    async_reset(2);
    hold(1'b1, 3);
    async_reset(1);
    hold(1'b0, 4);

    // Random button activity, with an occasional reset pulse.
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 29) == 0) async_reset(1);
      hold(1'($urandom % 2), $urandom_range(1, 12));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
